// File: rtl/data_memory_dumper.sv
// Streams every data memory entry, lowest address first, to a valid/ready transmitter.
// Define DUMP_CHECKSUM_EN to append the XOR of all dumped bytes as one extra byte.
//
// state | meaning
// IDLE  | waiting for i_start
// REQ   | one-cycle debug read strobe at the current address
// WAIT  | memory registers the byte; captured into the tx register
// SEND  | byte offered to the transmitter until accepted
// CSUM  | checksum byte offered (DUMP_CHECKSUM_EN only)
// DONE  | one-cycle completion pulse
module data_memory_dumper #(
  parameter int MEMORY_WIDTH = 8,
  parameter int MEMORY_DEPTH = 128,
  parameter int NB_ADDR      = 7
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_start,
  output logic                    o_mem_enable,
  output logic                    o_mem_read_enable,
  output logic [NB_ADDR-1:0]      o_mem_read_address,
  input  logic [MEMORY_WIDTH-1:0] i_mem_byte_data,
  output logic [MEMORY_WIDTH-1:0] o_tx_data,
  output logic                    o_tx_valid,
  input  logic                    i_tx_ready,
  output logic                    o_busy,
  output logic                    o_done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_SEND,
`ifdef DUMP_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_DONE
  } state_t;

  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(MEMORY_DEPTH - 1);

  state_t                  state_q, state_d;
  logic [NB_ADDR-1:0]      cnt_q, cnt_d;
  logic [MEMORY_WIDTH-1:0] tx_data_q, tx_data_d;
`ifdef DUMP_CHECKSUM_EN
  logic [MEMORY_WIDTH-1:0] csum_q, csum_d;
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tx_data_q <= '0;
`ifdef DUMP_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
`ifdef DUMP_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
`ifdef DUMP_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          cnt_d   = '0;
          state_d = ST_REQ;
`ifdef DUMP_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      ST_REQ: state_d = ST_WAIT;
      ST_WAIT: begin
        tx_data_d = i_mem_byte_data;
`ifdef DUMP_CHECKSUM_EN
        csum_d    = csum_q ^ i_mem_byte_data;
`endif
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (i_tx_ready) begin
          if (cnt_q == LAST_ADDR) begin
            // counter parks on the last address; a new i_start reloads it
`ifdef DUMP_CHECKSUM_EN
            tx_data_d = csum_q;
            state_d   = ST_CSUM;
`else
            state_d   = ST_DONE;
`endif
          end else begin
            cnt_d   = cnt_q + NB_ADDR'(1);
            state_d = ST_REQ;
          end
        end
      end
`ifdef DUMP_CHECKSUM_EN
      ST_CSUM: begin
        if (i_tx_ready) state_d = ST_DONE;
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy             = (state_q != ST_IDLE);
    o_mem_enable       = (state_q != ST_IDLE);
    o_mem_read_enable  = (state_q == ST_REQ);
    o_mem_read_address = cnt_q;
    o_tx_data          = tx_data_q;
`ifdef DUMP_CHECKSUM_EN
    o_tx_valid         = (state_q == ST_SEND) || (state_q == ST_CSUM);
`else
    o_tx_valid         = (state_q == ST_SEND);
`endif
    o_done             = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_data_memory_dumper.sv
// Scoreboarded bench for data_memory_dumper: expected byte stream queued at start,
// popped by an independent monitor on each accepted transfer.
module tb_data_memory_dumper;
  localparam int W = 8;
  localparam int D = 128;
  localparam int A = 7;
`ifdef DUMP_CHECKSUM_EN
  localparam int LAT = 3 * D + 1;
`else
  localparam int LAT = 3 * D;
`endif

  logic         i_clock = 1'b0;
  logic         i_reset = 1'b1;
  logic         i_start = 1'b0;
  logic         i_tx_ready = 1'b1;
  logic [W-1:0] i_mem_byte_data = '0;
  logic         o_mem_enable, o_mem_read_enable, o_tx_valid, o_busy, o_done;
  logic [A-1:0] o_mem_read_address;
  logic [W-1:0] o_tx_data;

  data_memory_dumper #(.MEMORY_WIDTH(W), .MEMORY_DEPTH(D), .NB_ADDR(A)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start),
    .o_mem_enable(o_mem_enable), .o_mem_read_enable(o_mem_read_enable),
    .o_mem_read_address(o_mem_read_address), .i_mem_byte_data(i_mem_byte_data),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clock = ~i_clock;

  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] mem [D];
  logic [W-1:0] exp_q [$];
  int           cycle = 0;
  int           first_req = -1;
  int           re_count = 0;
  int           done_seen = 0;
  int           bytes_acc = 0;
  bit           have_hold = 0;
  logic [W-1:0] held = '0;
  bit           ready_rand = 0;
  bit           check_lat = 0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge i_clock) cycle++;

  // memory registers the addressed byte one cycle after the strobe
  always @(posedge i_clock)
    if (o_mem_read_enable) i_mem_byte_data <= mem[o_mem_read_address];

  always @(posedge i_clock) begin
    #1;
    if (ready_rand) i_tx_ready = 1'($urandom_range(0, 1));
    else            i_tx_ready = 1'b1;
  end

  always @(negedge i_clock) begin
    if (i_reset) begin
      re_count  = 0;
      first_req = -1;
      have_hold = 0;
      bytes_acc = 0;
    end else begin
      if (o_mem_read_enable) begin
        if (first_req < 0) first_req = cycle;
        re_count++;
        chk(int'(o_mem_read_address) <= D - 1, "addr_range", int'(o_mem_read_address), D - 1);
      end
      if (o_tx_valid) begin
        if (have_hold) chk(o_tx_data == held, "tx_stable", int'(o_tx_data), int'(held));
        if (i_tx_ready) begin
          have_hold = 0;
          bytes_acc++;
          chk(exp_q.size() > 0, "extra_byte", int'(o_tx_data), -1);
          if (exp_q.size() > 0) begin
            automatic logic [W-1:0] e = exp_q.pop_front();
            chk(o_tx_data == e, "tx_byte", int'(o_tx_data), int'(e));
          end
        end else begin
          have_hold = 1;
          held      = o_tx_data;
        end
      end else begin
        have_hold = 0;
      end
      if (o_done) begin
        done_seen++;
        chk(re_count == D, "read_strobes", re_count, D);
        chk(exp_q.size() == 0, "bytes_missing", exp_q.size(), 0);
        if (check_lat) chk(cycle - first_req == LAT, "latency", cycle - first_req, LAT);
        re_count  = 0;
        first_req = -1;
        bytes_acc = 0;
      end
    end
  end

  task automatic push_dump();
`ifdef DUMP_CHECKSUM_EN
    logic [W-1:0] x = '0;
`endif
    for (int i = 0; i < D; i++) begin
      exp_q.push_back(mem[i]);
`ifdef DUMP_CHECKSUM_EN
      x ^= mem[i];
`endif
    end
`ifdef DUMP_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic start_dump();
    @(posedge i_clock); #2;
    i_start = 1'b1;
    push_dump();
    @(posedge i_clock); #2;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int n = 0;
    while (done_seen == prev && n < 3000) begin
      @(posedge i_clock);
      n++;
    end
    chk(done_seen == prev + 1, "done_timeout", done_seen, prev + 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk(o_busy == 1'b0 && o_mem_enable == 1'b0, {tag, "_busy"}, int'(o_busy), 0);
    chk(o_mem_read_enable == 1'b0 && o_mem_read_address == '0, {tag, "_rd"}, int'(o_mem_read_address), 0);
    chk(o_tx_valid == 1'b0 && o_tx_data == '0, {tag, "_tx"}, int'(o_tx_data), 0);
    chk(o_done == 1'b0, {tag, "_done"}, int'(o_done), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    int n;
    for (int i = 0; i < D; i++)
      mem[i] = (i == 0) ? 8'h5A : (i == 1) ? 8'hFF : W'(i & 8'hFF);

    // reset values, then start on the first edge after release
    #12;
    check_zero_outputs("reset");
    #20;
    check_lat = 1;
    i_reset = 1'b0;
    i_start = 1'b1;
    push_dump();
    @(negedge i_clock); #1;
    chk(o_mem_read_enable == 1'b1, "first_edge_start", int'(o_mem_read_enable), 1);
    chk(o_mem_read_address == '0, "first_addr", int'(o_mem_read_address), 0);
    @(posedge i_clock); #2;
    i_start = 1'b0;
    wait_done(0);
    check_lat = 0;
    repeat (5) @(posedge i_clock);
    #2;
    chk(o_busy == 1'b0, "idle_after_done", int'(o_busy), 0);

    // random content, random back-pressure
    ready_rand = 1;
    for (int i = 0; i < D; i++) mem[i] = W'($urandom);
    prev = done_seen;
    start_dump();
    wait_done(prev);

    // i_start at byte 10 and during DONE must be ignored
    for (int i = 0; i < D; i++) mem[i] = W'($urandom);
    prev = done_seen;
    start_dump();
    n = 0;
    while (bytes_acc < 10 && n < 1000) begin @(posedge i_clock); n++; end
    chk(bytes_acc >= 10, "reach_byte10", bytes_acc, 10);
    @(posedge i_clock); #2; i_start = 1'b1;
    @(posedge i_clock); #2; i_start = 1'b0;
    n = 0;
    while (!o_done && n < 3000) begin @(negedge i_clock); n++; end
    chk(o_done == 1'b1, "reach_done", int'(o_done), 1);
    #1 i_start = 1'b1;
    @(posedge i_clock); #2; i_start = 1'b0;
    repeat (20) @(posedge i_clock);
    #2;
    chk(done_seen == prev + 1, "single_done", done_seen, prev + 1);
    chk(o_busy == 1'b0, "no_restart", int'(o_busy), 0);

    // reset while sending address 50 aborts; next dump restarts at 0
    for (int i = 0; i < D; i++) mem[i] = W'($urandom);
    prev = done_seen;
    start_dump();
    n = 0;
    while (!(o_tx_valid && o_mem_read_address == A'(50)) && n < 3000) begin
      @(negedge i_clock); n++;
    end
    chk(o_tx_valid && o_mem_read_address == A'(50), "reach_addr50", int'(o_mem_read_address), 50);
    #2 i_reset = 1'b1;
    #1;
    check_zero_outputs("abort");
    exp_q.delete();
    @(posedge i_clock);
    @(posedge i_clock); #2;
    i_reset = 1'b0;
    repeat (5) @(posedge i_clock);
    chk(done_seen == prev, "no_done_on_abort", done_seen, prev);
    start_dump();
    wait_done(prev);

`ifdef DUMP_CHECKSUM_EN
    for (int i = 0; i < D; i++) mem[i] = (i == 3) ? 8'hA5 : 8'h00;
    prev = done_seen;
    start_dump();
    wait_done(prev);
`endif

    repeat (3) @(posedge i_clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/data_memory_dumper.md
DATA_MEMORY_DUMPER -- requirements
Module: data_memory_dumper

Interface
REQ-001 Parameter MEMORY_WIDTH, default 8: width of one data memory entry and of one transmitted byte.
REQ-002 Parameter MEMORY_DEPTH, default 128: number of data memory entries to dump.
REQ-003 Parameter NB_ADDR, default 7: width of the data memory debug read address.
REQ-004 i_clock  input  1  sole clock; all state updates on rising edge.
REQ-005 i_reset  input  1  asynchronous, active-high reset.
REQ-006 i_start  input  1  request one full dump; sampled only in IDLE.
REQ-007 o_mem_enable  output  1  data memory enable, high while the block is not IDLE.
REQ-008 o_mem_read_enable  output  1  data memory debug read strobe.
REQ-009 o_mem_read_address  output  NB_ADDR  data memory debug read address.
REQ-010 i_mem_byte_data  input  MEMORY_WIDTH  data memory debug byte, registered by memory one cycle after strobe.
REQ-011 o_tx_data  output  MEMORY_WIDTH  byte offered to the transmitter.
REQ-012 o_tx_valid  output  1  o_tx_data valid; held until accepted.
REQ-013 i_tx_ready  input  1  transmitter accepts byte on an edge where o_tx_valid and i_tx_ready are both high.
REQ-014 o_busy  output  1  high in every state except IDLE.
REQ-015 o_done  output  1  one-cycle pulse after the final byte is accepted.

Function
REQ-016 The FSM SHALL have states IDLE, REQ, WAIT, SEND, DONE (plus CSUM when DUMP_CHECKSUM_EN is defined).
REQ-017 IDLE: on i_start=1, address counter SHALL load 0 and FSM SHALL go to REQ; otherwise stay.
REQ-018 REQ: o_mem_read_enable=1 for exactly one cycle with o_mem_read_address=counter; next state WAIT.
REQ-019 WAIT: i_mem_byte_data SHALL be captured into the o_tx_data register at the end of this cycle; next state SEND.
REQ-020 SEND: o_tx_valid=1, o_tx_data stable; stay in SEND while i_tx_ready=0.
REQ-021 SEND with i_tx_ready=1 and counter < MEMORY_DEPTH-1: counter increments by 1, next state REQ.
REQ-022 SEND with i_tx_ready=1 and counter = MEMORY_DEPTH-1: next state DONE (or CSUM when enabled); counter SHALL NOT wrap to 0 and re-issue a read.
REQ-023 DONE: o_done=1 for one cycle, next state IDLE; i_start during DONE SHALL be ignored.
REQ-024 i_start in any state other than IDLE SHALL be ignored; no dump restarts mid-operation.
REQ-025 o_mem_read_enable SHALL be 0 outside REQ; o_tx_valid SHALL be 0 outside SEND/CSUM.
REQ-026 Minimum cost per byte with i_tx_ready held 1: 3 cycles (REQ, WAIT, SEND); full dump of 128 bytes SHALL take 384 cycles from first REQ to DONE.
REQ-027 Bytes SHALL be emitted in ascending address order 0 .. MEMORY_DEPTH-1, exactly once each.

Reset
REQ-028 i_reset=1 SHALL immediately force IDLE, counter=0, o_tx_data=0, and all 1-bit outputs and o_mem_read_address to 0, regardless of clock.
REQ-029 Reset asserted mid-dump SHALL abort the dump with no o_done pulse; a later i_start restarts from address 0.
REQ-030 First i_start SHALL be honoured on the first rising edge after i_reset deasserts.

Configuration
REQ-031 Macro DUMP_CHECKSUM_EN: when defined, a running XOR of all dumped bytes (cleared on i_start acceptance and on reset) SHALL be sent as one extra byte in state CSUM, same valid/ready rules as SEND, before DONE.
REQ-032 When DUMP_CHECKSUM_EN is undefined, no checksum register or CSUM state exists and exactly MEMORY_DEPTH bytes are sent.

Verification
REQ-033 Memory model bytes 0x5A, 0xFF, then addr&0xFF; i_start pulse, i_tx_ready=1 -> stream 0x5A,0xFF,0x02..0x7F, o_done at cycle 384 after first REQ.
REQ-034 i_tx_ready toggled 0/1 randomly -> identical byte stream, each byte accepted exactly once, o_tx_data stable while stalled.
REQ-035 i_start pulsed again at byte 10 and during DONE -> no restart, single o_done, 128 bytes total.
REQ-036 i_reset asserted while in SEND at address 50 -> outputs zero same cycle, no o_done; new i_start -> dump from address 0.
REQ-037 DUMP_CHECKSUM_EN defined, all memory 0x00 except addr 3 = 0xA5 -> 129th byte 0xA5, then o_done.
REQ-038 Check o_mem_read_enable is high exactly 128 cycles per dump, address never exceeds 127.
